// File: rtl/dcache_dm_wb.sv
// Direct-mapped write-back / write-allocate D-cache with 128-bit block refill and eviction.
// Optional hit/miss counters are enabled by defining DCACHE_PERF_CNT_EN.
module dcache_dm_wb #(
    parameter int NUM_BLOCKS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);
    localparam int IDX   = $clog2(NUM_BLOCKS);
    localparam int TAG_W = 28 - IDX;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

    state_e                  state_q;
    logic [NUM_BLOCKS-1:0]   valid_q, dirty_q;
    logic [TAG_W-1:0]        tag_q  [NUM_BLOCKS];
    logic [3:0][31:0]        data_q [NUM_BLOCKS];
    logic                    mem_read_q, mem_write_q;
    logic [27:0]             mem_addr_q;
    logic [127:0]            mem_wdata_q;

    logic [IDX-1:0]          idx;
    logic [TAG_W-1:0]        tag;
    logic [1:0]              word;
    logic                    req, hit;

    assign idx  = proc_addr[IDX+1:2];
    assign tag  = proc_addr[29:IDX+2];
    assign word = proc_addr[1:0];
    assign req  = proc_read | proc_write;
    assign hit  = valid_q[idx] && (tag_q[idx] == tag);

    assign proc_stall = (state_q != IDLE) || (req && !hit);
    assign proc_rdata = (state_q == IDLE && hit) ? data_q[idx][word] : 32'd0;

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (proc_write) dirty_q[idx] <= 1'b1;
                        end else if (valid_q[idx] && dirty_q[idx]) begin
                            state_q     <= WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[idx], idx};
                            mem_wdata_q <= data_q[idx];
                        end else begin
                            state_q    <= ALLOCATE;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= proc_addr[29:2];
                        end
                    end
                end
                WRITEBACK: begin
                    // Refill request goes out on the same edge the eviction completes.
                    if (mem_ready) begin
                        mem_write_q  <= 1'b0;
                        mem_read_q   <= 1'b1;
                        mem_addr_q   <= proc_addr[29:2];
                        dirty_q[idx] <= 1'b0;
                        state_q      <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        mem_read_q   <= 1'b0;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag/data arrays are never cleared; reset only blocks writes so an aborted refill leaves the line alone.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == IDLE && req && hit && proc_write) begin
                data_q[idx][word] <= proc_wdata;
            end else if (state_q == ALLOCATE && mem_ready) begin
                data_q[idx] <= mem_rdata;
                tag_q[idx]  <= tag;
            end
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        refill_q;

    // The completion hit right after a refill belongs to the miss, not to the hit count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            refill_q   <= 1'b0;
        end else begin
            if (state_q == ALLOCATE && mem_ready) refill_q <= 1'b1;
            else if (state_q == IDLE)             refill_q <= 1'b0;
            if (state_q == IDLE && req && hit && !refill_q) hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (state_q == IDLE && req && !hit)             miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Random + directed bench for dcache_dm_wb against a flat-memory model with resident-block tracking.
module tb_dcache_dm_wb;
    localparam int NB  = 8;
    localparam int IDX = 3;

    logic         clk, rst_n;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata, proc_rdata;
    logic         proc_stall;
    logic         mem_read, mem_write, mem_ready;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    dcache_dm_wb #(.NUM_BLOCKS(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata),
        .proc_rdata(proc_rdata), .proc_stall(proc_stall),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int force_lat = -1;

    // Model: what the core should observe, what memory holds, and which block sits at each index.
    logic [31:0]  truth [logic [29:0]];
    logic [127:0] bmem  [logic [27:0]];
    logic [127:0] imem  [logic [27:0]];
    bit           mv [NB];
    bit           md [NB];
    logic [27:0]  mblk [NB];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        logic [127:0] b;
        if (imem.exists(wa[29:2])) begin
            b = imem[wa[29:2]];
            return b[wa[1:0]*32 +: 32];
        end
        return {2'b00, wa} * 32'h9E3779B1 + 32'h5BD1E995;
    endfunction

    function automatic logic [31:0] truth_rd(input logic [29:0] wa);
        if (truth.exists(wa)) return truth[wa];
        return init_word(wa);
    endfunction

    function automatic logic [127:0] truth_blk(input logic [27:0] b);
        logic [127:0] r;
        for (int w = 0; w < 4; w++) r[w*32 +: 32] = truth_rd({b, w[1:0]});
        return r;
    endfunction

    function automatic logic [127:0] mem_blk(input logic [27:0] b);
        logic [127:0] r;
        if (bmem.exists(b)) return bmem[b];
        for (int w = 0; w < 4; w++) r[w*32 +: 32] = init_word({b, w[1:0]});
        return r;
    endfunction

    // Dirty lines are lost by reset: the visible value falls back to memory.
    task automatic model_reset();
        logic [127:0] b;
        for (int i = 0; i < NB; i++) begin
            if (mv[i] && md[i]) begin
                b = mem_blk(mblk[i]);
                for (int w = 0; w < 4; w++) truth[{mblk[i], w[1:0]}] = b[w*32 +: 32];
            end
            mv[i] = 0;
            md[i] = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; proc_read = 1'b0; proc_write = 1'b0; mem_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic access(input bit rd, input bit wr, input logic [29:0] a, input logic [31:0] d);
        int stalls = 0, cnt = 0, lat = 0, cur = 0, typ, rlat = 0, wlat = 0, expst;
        bit done = 0, wb_seen = 0, hit_exp, dv;
        logic [IDX-1:0] ix;
        logic [27:0] vblk;
        ix = a[IDX+1:2];
        hit_exp = mv[ix] && (mblk[ix] == a[29:2]);
        dv      = !hit_exp && mv[ix] && md[ix];
        vblk    = mblk[ix];
        proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = d;
        while (!done) begin
            @(negedge clk);
            if (!proc_stall) done = 1;
            else begin
                stalls++;
                chk("rd_wr_excl", {127'd0, mem_read & mem_write}, 128'd0);
                typ = mem_write ? 1 : (mem_read ? 2 : 0);
                if (typ != 0 && typ != cur) begin
                    cur = typ; cnt = 0;
                    lat = (force_lat >= 0) ? force_lat : $urandom_range(0, 4);
                    if (typ == 1) begin
                        wlat = lat; wb_seen = 1;
                        chk("wb_addr", {100'd0, mem_addr}, {100'd0, vblk});
                        chk("wb_data", mem_wdata, truth_blk(vblk));
                    end else begin
                        rlat = lat;
                        chk("rf_addr", {100'd0, mem_addr}, {100'd0, a[29:2]});
                    end
                end
                mem_ready = 1'b0;
                if (typ != 0) begin
                    if (cnt == lat) begin
                        mem_ready = 1'b1;
                        if (typ == 1) begin
                            bmem[vblk] = mem_wdata;
                            mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
                        end else begin
                            mem_rdata = mem_blk(a[29:2]);
                        end
                    end else cnt++;
                end
                if (stalls > 100) begin
                    chk("timeout", 128'(stalls), 128'd0);
                    done = 1;
                end
                @(posedge clk); #1;
                mem_ready = 1'b0;
            end
        end
        expst = hit_exp ? 0 : (2 + rlat + (dv ? wlat + 1 : 0));
        chk("stall_cycles", 128'(stalls), 128'(expst));
        chk("wb_happened", {127'd0, wb_seen}, {127'd0, dv});
        if (rd && !wr) chk("rdata", {96'd0, proc_rdata}, {96'd0, truth_rd(a)});
        chk("mem_quiet", {126'd0, mem_read, mem_write}, 128'd0);
        if (!hit_exp) begin mv[ix] = 1; mblk[ix] = a[29:2]; md[ix] = 0; end
        if (wr) begin md[ix] = 1; truth[a] = d; end
        @(posedge clk); #1;
        proc_read = 1'b0; proc_write = 1'b0;
    endtask

    initial begin
        logic [29:0] a;
        int k;
        bit to;
        proc_read = 0; proc_write = 0; proc_addr = '0; proc_wdata = '0;
        mem_ready = 0; mem_rdata = '0; rst_n = 0;
        for (int i = 0; i < NB; i++) begin mv[i] = 0; md[i] = 0; mblk[i] = '0; end
        do_reset();

        @(negedge clk);
        chk("rst_stall", {127'd0, proc_stall}, 128'd0);
        chk("rst_rdata", {96'd0, proc_rdata}, 128'd0);
        chk("rst_mrd",   {127'd0, mem_read}, 128'd0);
        chk("rst_mwr",   {127'd0, mem_write}, 128'd0);
        chk("rst_maddr", {100'd0, mem_addr}, 128'd0);
        chk("rst_mwdata", mem_wdata, 128'd0);
        @(posedge clk); #1;

        // Clean miss with 3-cycle memory: 5 stall cycles, word 0 = 0xAAAA.
        imem[28'h4] = {32'h0000DDDD, 32'h0000CCCC, 32'h0000BBBB, 32'h0000AAAA};
        force_lat = 3;
        access(1, 0, 30'h10, 32'd0);
        access(1, 0, 30'h10, 32'd0);
        access(0, 1, 30'h11, 32'h12345678);
        access(1, 0, 30'h11, 32'd0);
        // Same index, new tag: dirty eviction of block 4 first.
        access(1, 0, 30'h11 + NB * 4, 32'd0);
        force_lat = -1;
        // Write miss to a clean line, then check merge and untouched words.
        access(0, 1, 30'h08, 32'hCAFEF00D);
        access(1, 0, 30'h09, 32'd0);
        access(1, 0, 30'h0B, 32'd0);
        access(1, 0, 30'h08, 32'd0);
        access(1, 0, 30'h08 + NB * 4, 32'd0);
        access(1, 1, 30'h0A, 32'h0BADBEEF);
        access(1, 0, 30'h0A, 32'd0);

        // Reset while a refill is outstanding.
        proc_read = 1; proc_write = 0; proc_addr = 30'h1C4;
        to = 1;
        for (int c = 0; c < 20 && to; c++) begin
            @(negedge clk);
            if (mem_read) to = 0;
        end
        chk("alloc_reached", {127'd0, to}, 128'd0);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("rst_drop_mrd", {127'd0, mem_read}, 128'd0);
        proc_read = 0;
        model_reset();
        @(posedge clk); #1;
        access(1, 0, 30'h1C4, 32'd0);

        // Random traffic over a small footprint so hits and conflicts both occur.
        for (int n = 0; n < 400; n++) begin
            a = 30'($urandom_range(0, NB * 16 - 1));
            if ($urandom_range(0, 7) == 0) a[29:24] = 6'($urandom);
            k = $urandom_range(0, 9);
            if (k < 5)       access(1, 0, a, 32'd0);
            else if (k < 9)  access(0, 1, a, $urandom);
            else             access(1, 1, a, $urandom);
            if ($urandom_range(0, 15) == 0) begin
                @(negedge clk);
                chk("idle_stall", {127'd0, proc_stall}, 128'd0);
                @(posedge clk); #1;
            end
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dcache_dm_wb.md
# dcache_dm_wb

Direct-mapped, write-back, write-allocate data cache that answers the pipeline core's D-cache request port (read/write enable, 30-bit word address, 32-bit data, stall). It is the responder on the core side and a 128-bit block-transfer initiator toward main memory. Hits complete in the same cycle with no stall. Misses hold `proc_stall` high while the block is written back and/or refilled.

## Interface
Parameters:
- `NUM_BLOCKS`, 8: number of cache lines. Power of two, at least 2. `IDX = log2(NUM_BLOCKS)`.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `proc_read`  in  1  core load request
- `proc_write`  in  1  core store request
- `proc_addr`  in  30  word address; [1:0] word-in-block, [IDX+1:2] index, [29:IDX+2] tag
- `proc_wdata`  in  32  store data
- `proc_rdata`  out  32  load data, valid when `proc_read` and not `proc_stall`
- `proc_stall`  out  1  request not complete; core holds request stable
- `mem_read`  out  1  block read request
- `mem_write`  out  1  block write request
- `mem_addr`  out  28  block address
- `mem_wdata`  out  128  victim block, word 0 in [31:0]
- `mem_rdata`  in  128  refill block, word 0 in [31:0]
- `mem_ready`  in  1  one-cycle pulse: memory completes the current request

## Operation
- Storage per line: valid bit, dirty bit, tag of (28-IDX) bits, 4×32 data words. Arrays are flops.
- Request = `proc_read | proc_write`. If both are high, the request is treated as a write and `proc_rdata` is don't-care.
- Hit = valid[idx] & (tag[idx] == addr tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - No request: `proc_stall`=0.
  - Read hit: `proc_rdata` = data[idx][word] (combinational), `proc_stall`=0.
  - Write hit: `proc_stall`=0. At the clock edge the word is updated and dirty is set.
  - Miss with dirty victim: `proc_stall`=1. Go to WRITEBACK. Register `mem_write`=1, `mem_addr`={victim tag, idx}, `mem_wdata`=victim line.
  - Miss with clean or invalid victim: `proc_stall`=1. Go to ALLOCATE. Register `mem_read`=1, `mem_addr`=proc_addr[29:2].
- WRITEBACK: `proc_stall`=1. Hold outputs until `mem_ready`. On `mem_ready`, clear `mem_write` and set `mem_read`=1 with `mem_addr`=proc_addr[29:2] at the same edge, then go to ALLOCATE. Clear dirty.
- ALLOCATE: `proc_stall`=1. On `mem_ready`:
  - line ← `mem_rdata`, valid=1, tag=addr tag, dirty=0;
  - clear `mem_read`;
  - go to IDLE.
  - The request then hits on the next cycle; write-allocate merging happens on that hit.
- `mem_ready` is ignored in IDLE. `mem_read` and `mem_write` are never high together.

## Timing
- Reset (synchronous, `rst_n`=0 at an edge):
  - all valid and dirty bits cleared; state=IDLE;
  - `mem_read`=`mem_write`=0, `mem_addr`=0, `mem_wdata`=0;
  - `proc_stall`=0 with no request, `proc_rdata`=0 with no hit.
  - Data and tag arrays are not cleared.
- Hit latency: 0 stall cycles.
- Clean miss: stall lasts 2 + W cycles, where W is the number of cycles from `mem_read` asserting to the `mem_ready` cycle (W≥0, counting the `mem_ready` cycle as the last wait cycle).
- Dirty miss: write-back duration is added to the clean-miss latency.
- Reset mid-miss: the transaction is abandoned. Memory requests drop on the next edge, and nothing is written to the line.
- Memory outputs are flop outputs. `proc_stall` and `proc_rdata` are combinational from state, arrays and `proc_*`.

## Configuration
- `DCACHE_PERF_CNT_EN` defined:
  - adds outputs `hit_cnt` and `miss_cnt`, each 32 bits, wrapping, reset to 0;
  - `hit_cnt` increments once per request completed in IDLE without a preceding miss;
  - `miss_cnt` increments once per IDLE→WRITEBACK/ALLOCATE transition;
  - the post-refill completion hit is not counted as a hit.
- Not defined: no counter ports or logic. Cache behaviour is identical.

## Test plan
- Reset, then read 0x0000_0010 (idx 4) → `proc_stall`=1. Next edge `mem_read`=1, `mem_addr`=0x000_0004. Memory returns 0x...DDDD_CCCC_BBBB_AAAA after 3 cycles → `proc_rdata`=0xAAAA in the cycle after `mem_ready`, stall low. Total stall 5 cycles.
- Same address read again → `proc_stall`=0 the same cycle, `proc_rdata`=0xAAAA, no memory request.
- Write 0x1234_5678 to addr 0x11 (hit), then read addr 0x11 → 0x1234_5678, zero stall, line dirty.
- Read addr 0x11 + (NUM_BLOCKS·4) (same index, new tag) → `mem_write`=1 with `mem_addr`=0x000_0004 and `mem_wdata`[63:32]=0x1234_5678. After `mem_ready`, `mem_read`=1 for the new block. Never both high.
- Write miss to a clean line → refill, then the word is merged with the write. Dirty=1, other three words equal the memory data.
- Assert `rst_n`=0 during ALLOCATE → next edge `mem_read`=0. Re-access the same address → it misses again.
